msrv32_pc_gen: RTL and testbench

- Parametrised, registered next-PC generator for the MSRV32 fetch stage.
- Selects among boot address, EPC, trap vector, branch target and sequential PC.
- Holds the fetch address while the AHB instruction bus stalls, and latches redirects that arrive during a stall so none are lost.
- Adds a boot-delay counter, a registered current-PC output and configurable branch-target alignment checking.

---
 rtl/msrv32_pc_gen_pkg.sv | 17 +
 rtl/msrv32_pc_gen_if.sv | 32 +++
 rtl/msrv32_pc_gen_next_sel.sv | 44 ++++
 rtl/msrv32_pc_gen.sv | 122 ++++++++++++
 tb/tb_msrv32_pc_gen.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/msrv32_pc_gen_pkg.sv
// Shared constants and types for the MSRV32 next-PC generator.
package msrv32_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_EPC  = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

endpackage

// File: rtl/msrv32_pc_gen_if.sv
// Control/bus bundle between the fetch control logic and the PC generator.
interface msrv32_pc_gen_if
    import msrv32_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic [1:0]      pc_src_in;
    logic [XLEN-1:0] epc_in;
    logic [XLEN-1:0] trap_address_in;
    logic            branch_taken_in;
    logic [XLEN-2:0] iaddr_in;
    logic            ahb_ready_in;
    logic [XLEN-1:0] iaddr_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus_4_out;
    logic [XLEN-1:0] pc_mux_out;
    logic            fetch_valid_out;
    logic            redirect_pending_out;
    logic            misaligned_instr_logic_out;

    modport master (
        output pc_src_in, epc_in, trap_address_in, branch_taken_in, iaddr_in, ahb_ready_in,
        input  iaddr_out, pc_out, pc_plus_4_out, pc_mux_out, fetch_valid_out,
               redirect_pending_out, misaligned_instr_logic_out
    );

    modport slave (
        input  pc_src_in, epc_in, trap_address_in, branch_taken_in, iaddr_in, ahb_ready_in,
        output iaddr_out, pc_out, pc_plus_4_out, pc_mux_out, fetch_valid_out,
               redirect_pending_out, misaligned_instr_logic_out
    );
endinterface

// File: rtl/msrv32_pc_gen_next_sel.sv
// Combinational next-address mux and branch-target alignment check.
// MSRV32_PC_C_EXT_EN: halfword-aligned targets are legal (no misaligned detection).
module msrv32_pc_next_sel
    import msrv32_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] BOOT_ADDRESS = '0
) (
    input  logic [1:0]      pc_src_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic [XLEN-1:0] trap_address_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-2:0] iaddr_i,
    input  logic [XLEN-1:0] seq_base_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic [XLEN-1:0] pc_mux_o,
    output logic            redirect_o,
    output logic            misaligned_o
);
    logic [XLEN-1:0] target;
    logic            aligned;

    assign target = {iaddr_i, 1'b0};

`ifdef MSRV32_PC_C_EXT_EN
    assign aligned = 1'b1;
`else
    assign aligned = ~target[1];
`endif

    assign misaligned_o = branch_taken_i & ~aligned;
    assign next_pc_o    = (branch_taken_i & aligned) ? target : seq_base_i + XLEN'(4);
    assign redirect_o   = (pc_src_i != PC_SRC_NEXT) | (branch_taken_i & aligned);

    always_comb begin
        pc_mux_o = next_pc_o;
        case (pc_src_i)
            PC_SRC_BOOT: pc_mux_o = BOOT_ADDRESS;
            PC_SRC_EPC:  pc_mux_o = epc_i;
            PC_SRC_TRAP: pc_mux_o = trap_address_i;
            default:     pc_mux_o = next_pc_o;
        endcase
    end
endmodule

// File: rtl/msrv32_pc_gen.sv
// Registered next-PC generator: boot delay, stall hold and latched redirects.
// Optional build macro: MSRV32_PC_C_EXT_EN (see msrv32_pc_next_sel).
module msrv32_pc_gen
    import msrv32_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
    parameter int              BOOT_CYCLES  = 1
) (
    input logic              clk_in,
    input logic              rst_in,
    msrv32_pc_gen_if.slave   bus
);
    localparam int             CNT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOOT_CYCLES - 1);

    pc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] iaddr_q, iaddr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_q, pending_d;
    logic            valid_q, valid_d;
    logic            pend_q, pend_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_mux;
    logic            redirect;
    logic            misaligned;

    // Sequential successor is taken from the address being accepted, so after
    // every accept iaddr_out = pc_out + 4.
    msrv32_pc_next_sel #(
        .XLEN         (XLEN),
        .BOOT_ADDRESS (BOOT_ADDRESS)
    ) u_next_sel (
        .pc_src_i       (bus.pc_src_in),
        .epc_i          (bus.epc_in),
        .trap_address_i (bus.trap_address_in),
        .branch_taken_i (bus.branch_taken_in),
        .iaddr_i        (bus.iaddr_in),
        .seq_base_i     (iaddr_q),
        .next_pc_o      (next_pc),
        .pc_mux_o       (pc_mux),
        .redirect_o     (redirect),
        .misaligned_o   (misaligned)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        iaddr_d   = iaddr_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        pend_d    = pend_q;
        mis_d     = misaligned;
        case (state_q)
            BOOT: begin
                cnt_d   = cnt_q + 1'b1;
                valid_d = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    iaddr_d = BOOT_ADDRESS;
                end
            end
            RUN: begin
                if (bus.ahb_ready_in) begin
                    pc_d    = iaddr_q;
                    iaddr_d = pc_mux;
                end else if (redirect) begin
                    pending_d = pc_mux;
                    pend_d    = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.ahb_ready_in) begin
                    pc_d      = iaddr_q;
                    iaddr_d   = redirect ? pc_mux : pending_q;
                    pending_d = BOOT_ADDRESS;
                    pend_d    = 1'b0;
                    state_d   = RUN;
                end else if (redirect) begin
                    pending_d = pc_mux;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= BOOT;
            cnt_q     <= '0;
            iaddr_q   <= BOOT_ADDRESS;
            pc_q      <= BOOT_ADDRESS;
            pending_q <= BOOT_ADDRESS;
            valid_q   <= 1'b0;
            pend_q    <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            iaddr_q   <= iaddr_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            pend_q    <= pend_d;
            mis_q     <= mis_d;
        end
    end

    assign bus.iaddr_out                  = iaddr_q;
    assign bus.pc_out                     = pc_q;
    assign bus.pc_plus_4_out              = pc_q + XLEN'(4);
    assign bus.pc_mux_out                 = pc_mux;
    assign bus.fetch_valid_out            = valid_q;
    assign bus.redirect_pending_out       = pend_q;
    assign bus.misaligned_instr_logic_out = mis_q;
endmodule

// File: tb/tb_msrv32_pc_gen.sv
// Directed table-driven bench for msrv32_pc_gen (XLEN=32, BOOT_CYCLES=3).
module tb_msrv32_pc_gen;
`ifdef MSRV32_PC_C_EXT_EN
    localparam bit C_EXT = 1'b1;
`else
    localparam bit C_EXT = 1'b0;
`endif

    typedef struct {
        logic [1:0]  src;
        logic [31:0] epc;
        logic [31:0] trap;
        logic        bt;
        logic [30:0] ia;
        logic        rdy;
        logic [31:0] mux;
        logic [31:0] iaddr;
        logic [31:0] pc;
        logic        valid;
        logic        pend;
        logic        mis;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[23];

    msrv32_pc_gen_if #(.XLEN(32)) bus ();

    msrv32_pc_gen #(
        .XLEN         (32),
        .BOOT_ADDRESS (32'h0),
        .BOOT_CYCLES  (3)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [1:0] src, logic [31:0] epc, logic [31:0] trap,
                                logic bt, logic [30:0] ia, logic rdy, logic [31:0] mux,
                                logic [31:0] iaddr, logic [31:0] pc, logic valid,
                                logic pend, logic mis);
        vec_t v;
        v.src = src; v.epc = epc; v.trap = trap; v.bt = bt; v.ia = ia; v.rdy = rdy;
        v.mux = mux; v.iaddr = iaddr; v.pc = pc; v.valid = valid; v.pend = pend; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] iaddr, input logic [31:0] pc,
                              input logic valid, input logic pend, input logic mis);
        chk({tag, ".iaddr"}, bus.iaddr_out, iaddr);
        chk({tag, ".pc"}, bus.pc_out, pc);
        chk({tag, ".pc4"}, bus.pc_plus_4_out, pc + 32'd4);
        chk({tag, ".valid"}, {31'd0, bus.fetch_valid_out}, {31'd0, valid});
        chk({tag, ".pend"}, {31'd0, bus.redirect_pending_out}, {31'd0, pend});
        chk({tag, ".mis"}, {31'd0, bus.misaligned_instr_logic_out}, {31'd0, mis});
    endtask

    task automatic drive(input logic [1:0] src, input logic [31:0] epc, input logic [31:0] trap,
                         input logic bt, input logic [30:0] ia, input logic rdy);
        bus.pc_src_in       = src;
        bus.epc_in          = epc;
        bus.trap_address_in = trap;
        bus.branch_taken_in = bt;
        bus.iaddr_in        = ia;
        bus.ahb_ready_in    = rdy;
    endtask

    initial begin
        // src, epc, trap, bt, ia, rdy | mux, iaddr, pc, valid, pend, mis
        vecs[0]  = mk(2'b11, 0, 0, 0, 31'h0, 1, 32'h4, 32'h0, 32'h0, 0, 0, 0);
        vecs[1]  = mk(2'b11, 0, 0, 0, 31'h0, 1, 32'h4, 32'h0, 32'h0, 0, 0, 0);
        vecs[2]  = mk(2'b11, 0, 0, 0, 31'h0, 1, 32'h4, 32'h0, 32'h0, 1, 0, 0);
        vecs[3]  = mk(2'b11, 0, 0, 0, 31'h0, 1, 32'h4, 32'h4, 32'h0, 1, 0, 0);
        vecs[4]  = mk(2'b11, 0, 0, 0, 31'h0, 1, 32'h8, 32'h8, 32'h4, 1, 0, 0);
        vecs[5]  = mk(2'b11, 0, 0, 1, 31'h7E, 1, 32'hFC, 32'hFC, 32'h8, 1, 0, 0);
        vecs[6]  = mk(2'b11, 0, 0, 0, 31'h0, 1, 32'h100, 32'h100, 32'hFC, 1, 0, 0);
        vecs[7]  = mk(2'b11, 0, 0, 0, 31'h0, 1, 32'h104, 32'h104, 32'h100, 1, 0, 0);
        vecs[8]  = mk(2'b11, 0, 0, 1, 31'h90, 1, 32'h120, 32'h120, 32'h104, 1, 0, 0);
        vecs[9]  = mk(2'b10, 0, 32'h800, 0, 31'h0, 0, 32'h800, 32'h120, 32'h104, 1, 1, 0);
        vecs[10] = mk(2'b11, 0, 0, 0, 31'h0, 0, 32'h124, 32'h120, 32'h104, 1, 1, 0);
        vecs[11] = mk(2'b11, 0, 0, 0, 31'h0, 1, 32'h124, 32'h800, 32'h120, 1, 0, 0);
        vecs[12] = mk(2'b10, 0, 32'h800, 0, 31'h0, 0, 32'h800, 32'h800, 32'h120, 1, 1, 0);
        vecs[13] = mk(2'b01, 32'h44, 0, 0, 31'h0, 0, 32'h44, 32'h800, 32'h120, 1, 1, 0);
        vecs[14] = mk(2'b11, 0, 0, 0, 31'h0, 1, 32'h804, 32'h44, 32'h800, 1, 0, 0);
        vecs[15] = mk(2'b10, 0, 32'h800, 0, 31'h0, 0, 32'h800, 32'h44, 32'h800, 1, 1, 0);
        vecs[16] = mk(2'b01, 32'h200, 0, 0, 31'h0, 1, 32'h200, 32'h200, 32'h44, 1, 0, 0);
        vecs[17] = mk(2'b11, 0, 0, 1, 31'h91, 1, C_EXT ? 32'h122 : 32'h204,
                      C_EXT ? 32'h122 : 32'h204, 32'h200, 1, 0, !C_EXT);
        vecs[18] = mk(2'b11, 0, 0, 0, 31'h0, 1, C_EXT ? 32'h126 : 32'h208,
                      C_EXT ? 32'h126 : 32'h208, C_EXT ? 32'h122 : 32'h204, 1, 0, 0);
        vecs[19] = mk(2'b10, 0, 32'h800, 1, 31'h91, 1, 32'h800, 32'h800,
                      C_EXT ? 32'h126 : 32'h208, 1, 0, !C_EXT);
        vecs[20] = mk(2'b11, 0, 0, 1, 31'h7FFF_FFFE, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                      32'h800, 1, 0, 0);
        vecs[21] = mk(2'b11, 0, 0, 0, 31'h0, 1, 32'h0, 32'h0, 32'hFFFF_FFFC, 1, 0, 0);
        vecs[22] = mk(2'b10, 0, 32'h800, 1, 31'h91, 0, 32'h800, 32'h0, 32'hFFFF_FFFC,
                      1, 1, !C_EXT);

        drive(2'b11, 0, 0, 0, 31'h0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_regs("reset", 32'h0, 32'h0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            rst = 1'b0;
            drive(vecs[i].src, vecs[i].epc, vecs[i].trap, vecs[i].bt, vecs[i].ia, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d.mux", i), bus.pc_mux_out, vecs[i].mux);
            @(posedge clk); #1;
            check_regs($sformatf("v%0d", i), vecs[i].iaddr, vecs[i].pc,
                       vecs[i].valid, vecs[i].pend, vecs[i].mis);
            $display("vec %0d src=%0d bt=%0d rdy=%0d -> iaddr=0x%08h pc=0x%08h pend=%0d mis=%0d",
                     i, vecs[i].src, vecs[i].bt, vecs[i].rdy, bus.iaddr_out, bus.pc_out,
                     bus.redirect_pending_out, bus.misaligned_instr_logic_out);
        end

        // Reset while stalled in HOLD with a misaligned branch still presented.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_regs("midrst", 32'h0, 32'h0, 0, 0, 0);
        $display("mid-HOLD reset -> iaddr=0x%08h pend=%0d", bus.iaddr_out, bus.redirect_pending_out);

        // Boot delay restarts from zero after the reset.
        @(negedge clk);
        rst = 1'b0;
        drive(2'b11, 0, 0, 0, 31'h0, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("reboot%0d.valid", k), {31'd0, bus.fetch_valid_out},
                {31'd0, (k == 2)});
            chk($sformatf("reboot%0d.iaddr", k), bus.iaddr_out, 32'h0);
            $display("reboot cycle %0d valid=%0d", k, bus.fetch_valid_out);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
